mem_line_resp: RTL and testbench

Memory-side responder serving cache line requests issued by cache_ctrl on a miss (refill read) or eviction (writeback write).
- Backed by an internal word-addressed RAM of MEM_DEPTH_WORDS words.
- Applies a programmable fixed access latency.
- Returns data or acknowledgement over a valid/ready response channel.
- Addresses beyond the RAM produce an error response, which the cache controller converts to i_segfault/d_segfault.

---
 rtl/mem_line_resp.sv | 175 +++++++++++++++++
 tb/tb_mem_line_resp.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_resp.sv
// Memory-side line responder: refill reads and writeback writes against an internal word RAM.
// Optional build macro MEM_LINE_RESP_CRITICAL_WORD_EN: read bursts start at the requested word and wrap.
module mem_line_resp #(
  parameter int unsigned LINE_WORDS      = 4,
  parameter int unsigned MEM_DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  input  logic        rsp_ready
);

  localparam int unsigned OW = $clog2(LINE_WORDS);
  localparam int unsigned AW = $clog2(MEM_DEPTH_WORDS);
  localparam int unsigned LW = AW - OW;
  localparam int unsigned CW = $clog2(LATENCY + 2);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WAIT,
    RD_BURST,
    ACK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] beat_q, beat_d;
  logic [OW-1:0] off_q, off_d;
  logic [LW-1:0] line_q, line_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic          mem_we;

  logic [31:0]   mem [MEM_DEPTH_WORDS];
  logic [29:0]   word_idx;
  logic [OW-1:0] rd_pos;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          last_beat;
  logic          unused_addr;

  assign word_idx    = req_addr[31:2];
  assign rd_pos      = beat_q + off_q;
  assign rd_idx      = {line_q, rd_pos};
  assign wr_idx      = {line_q, beat_q};
  assign last_beat   = (beat_q == OW'(LINE_WORDS - 1));
  assign unused_addr = &{1'b0, req_addr[1:0], word_idx[OW-1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      off_q   <= '0;
      line_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      off_q   <= off_d;
      line_q  <= line_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; a beat sampled together with reset is not written.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    off_d     = off_q;
    line_d    = line_q;
    wr_d      = wr_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wr_d   = req_wr;
          err_d  = (word_idx >= 30'(MEM_DEPTH_WORDS));
          line_d = word_idx[AW-1:OW];
          beat_d = '0;
`ifdef MEM_LINE_RESP_CRITICAL_WORD_EN
          off_d  = req_wr ? '0 : word_idx[OW-1:0];
`else
          off_d  = '0;
`endif
          if (req_wr) begin
            state_d = WR_DATA;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY);
          end
        end
      end

      WR_DATA: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_we = !err_q;
          beat_d = beat_q + OW'(1);
          if (last_beat) begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY);
          end
        end
      end

      // Leaving when the counter is at 1 (or 0) gives LATENCY wait cycles, with a floor of one.
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
        if (cnt_q <= CW'(1)) begin
          state_d = (wr_q || err_q) ? ACK : RD_BURST;
        end
      end

      RD_BURST: begin
        rsp_valid = 1'b1;
        rsp_data  = mem[rd_idx];
        rsp_last  = last_beat;
        if (rsp_ready) begin
          beat_d = beat_q + OW'(1);
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end

      ACK: begin
        rsp_valid = 1'b1;
        rsp_last  = 1'b1;
        rsp_err   = err_q;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_line_resp.sv
// Scoreboard bench for mem_line_resp: directed scenarios followed by randomized line traffic.
module tb_mem_line_resp;

  localparam int LWORDS = 4;
  localparam int DEPTH  = 4096;
  localparam int LAT    = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        rsp_ready;

  mem_line_resp #(
    .LINE_WORDS     (LWORDS),
    .MEM_DEPTH_WORDS(DEPTH),
    .LATENCY        (LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_last (rsp_last),
    .rsp_err  (rsp_err),
    .rsp_ready(rsp_ready)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
    int          due;
  } exp_t;

  exp_t              exp_q[$];
  logic [31:0]       mdl[int unsigned];
  int unsigned       lines[$];
  int                errors = 0;
  int                checks = 0;
  int                cyc = 0;
  int                last_done = -1;
  int                bp_mode = 0;
  logic              prev_v = 1'b0;
  logic              prev_r = 1'b0;
  logic [31:0]       prev_d = '0;
  logic              prev_l = 1'b0;
  logic              prev_e = 1'b0;
  logic              in_rsp = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  // Response ready: 0 = always ready, 1 = random backpressure, 2 = held low.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 1)      rsp_ready = ($urandom_range(0, 2) != 0);
      else if (bp_mode == 2) rsp_ready = 1'b0;
      else                   rsp_ready = 1'b1;
    end
  end

  // Monitor: compares every accepted beat and the hold rule under backpressure.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v = 1'b0;
      in_rsp = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold_data", rsp_data, prev_d);
        chk("hold_last", {31'd0, rsp_last}, {31'd0, prev_l});
        chk("hold_err", {31'd0, rsp_err}, {31'd0, prev_e});
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          note_fail("unexpected_rsp");
        end else begin
          if (!in_rsp) begin
            if (exp_q[0].due >= 0) chk("first_beat_cycle", cyc, exp_q[0].due);
            in_rsp = 1'b1;
          end
          if (rsp_ready) begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_last", {31'd0, rsp_last}, {31'd0, e.last});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            if (e.last) begin
              in_rsp    = 1'b0;
              last_done = cyc;
            end
          end
        end
      end
      prev_v = rsp_valid;
      prev_r = rsp_ready;
      prev_d = rsp_data;
      prev_l = rsp_last;
      prev_e = rsp_err;
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, output int t);
    int n;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    n = 0;
    t = -1;
    forever begin
      @(negedge clk);
      if (req_ready) begin
        t = cyc;
        break;
      end
      n++;
      if (n > 200) begin
        note_fail("req_accept_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = $urandom;
  endtask

  // Reference: expected beats derived from address arithmetic over the word model.
  task automatic push_read(input logic [31:0] addr, input int t);
    int unsigned widx, base, start, w;
    exp_t e;
    widx = addr >> 2;
    if (widx >= DEPTH) begin
      e.data = '0; e.last = 1'b1; e.err = 1'b1; e.due = t + LAT + 1;
      exp_q.push_back(e);
    end else begin
      base  = widx - (widx % LWORDS);
      start = 0;
`ifdef MEM_LINE_RESP_CRITICAL_WORD_EN
      start = widx % LWORDS;
`endif
      for (int k = 0; k < LWORDS; k++) begin
        w      = base + ((start + k) % LWORDS);
        e.data = mdl.exists(w) ? mdl[w] : 32'h0;
        e.last = (k == LWORDS - 1);
        e.err  = 1'b0;
        e.due  = (k == 0) ? t + LAT + 1 : -1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_read(input logic [31:0] addr, output int t);
    do_req(1'b0, addr, t);
    push_read(addr, t);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] d [LWORDS], input bit gaps);
    int t, n, l;
    int unsigned widx, base;
    exp_t e;
    do_req(1'b1, addr, t);
    l = -1;
    for (int i = 0; i < LWORDS; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      wr_valid = 1'b1;
      wr_data  = d[i];
      n = 0;
      forever begin
        @(negedge clk);
        if (wr_ready) break;
        n++;
        if (n > 200) begin
          note_fail("wr_beat_timeout");
          break;
        end
      end
      l = cyc;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
    end
    widx = addr >> 2;
    base = widx - (widx % LWORDS);
    if (widx < DEPTH) begin
      for (int i = 0; i < LWORDS; i++) mdl[base + i] = d[i];
    end
    e.data = '0; e.last = 1'b1; e.err = (widx >= DEPTH); e.due = l + LAT + 1;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 || rsp_valid) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        note_fail("drain_timeout");
        exp_q.delete();
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a [LWORDS];
    logic [31:0] b [LWORDS];
    logic [31:0] c [LWORDS];
    logic [31:0] r [LWORDS];
    logic [31:0] addr;
    int t, t2;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    for (int i = 0; i < LWORDS; i++) begin
      a[i] = 32'hA0A0_0000 + i;
      b[i] = 32'hB0B0_0000 + i;
      c[i] = 32'hC0C0_0000 + i;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_last", {31'd0, rsp_last}, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_write(32'h100, a, 1'b0);
    do_read(32'h100, t);
    drain();

    do_read(32'h100, t);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bp_mode = 2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bp_mode = 0;
    drain();

    do_write(32'h0, b, 1'b0);
    do_read(32'h4000, t);
    do_write(32'h4000, c, 1'b0);
    do_read(32'h0, t);
    drain();

    do_read(32'h10C, t);
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    wr_valid = 1'b0;
    drain();
    do_read(32'h100, t);
    drain();

    do_read(32'h100, t);
    do_req(1'b0, 32'h104, t2);
    chk("busy_accept_cycle", t2, last_done + 1);
    push_read(32'h104, t2);
    drain();

    do_read(32'h100, t);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midreset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midreset_wr_ready", {31'd0, wr_ready}, 32'd0);
    do_read(32'h100, t);
    drain();

    lines.push_back(32'h100);
    lines.push_back(32'h0);
    bp_mode = 1;
    for (int op = 0; op < 60; op++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          addr = {18'd0, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 4'd0};
          for (int i = 0; i < LWORDS; i++) r[i] = $urandom;
          do_write(addr | 32'($urandom_range(0, 15)), r, 1'b1);
          lines.push_back(addr);
        end
        2: begin
          addr = $urandom;
          if ((addr >> 2) < DEPTH) addr = addr | 32'h8000_0000;
          if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i < LWORDS; i++) r[i] = $urandom;
            do_write(addr, r, 1'b1);
          end else begin
            do_read(addr, t);
          end
        end
        default: begin
          addr = lines[$urandom_range(0, lines.size() - 1)] + 32'($urandom_range(0, 15));
          do_read(addr, t);
        end
      endcase
    end
    bp_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
